// File: rtl/core_run_ctrl_pkg.sv
// rtl/core_run_ctrl_pkg.sv - mode and state encodings shared by the run/step controller
package core_run_ctrl_pkg;

    localparam logic [1:0] MODE_HALT  = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_RUN_N = 2'b11;

    typedef enum logic [2:0] {
        ST_HALT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_RUN_N = 3'd3,
        ST_BREAK = 3'd4
    } run_state_t;

    // RUN_N is only entered through start, so a bare switch to mode 11 parks in HALT.
    function automatic run_state_t mode_state(input logic [1:0] mode);
        run_state_t st;
        st = ST_HALT;
        case (mode)
            MODE_RUN:  st = ST_RUN;
            MODE_STEP: st = ST_STEP;
            default:   st = ST_HALT;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/core_run_ctrl_step_sync.sv
// rtl/core_run_ctrl_step_sync.sv - step button synchronizer with rising-edge pulse
module core_run_ctrl_step_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_step,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_step;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - clock-enable run/step controller with divider, run-N, breakpoints
module core_run_ctrl
    import core_run_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH = 4,
    parameter int PC_WIDTH  = 64,
    parameter int NUM_BP    = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [1:0]                 i_mode,
    input  logic [DIV_WIDTH-1:0]       i_div_sel,
    input  logic                       i_step,
    input  logic                       i_start,
    input  logic [CNT_WIDTH-1:0]       i_run_count,
    input  logic [PC_WIDTH-1:0]        i_pc,
    input  logic [NUM_BP*PC_WIDTH-1:0] i_bp_addr,
    input  logic [NUM_BP-1:0]          i_bp_en,
    input  logic                       i_stall,
    output logic                       o_cpu_ce,
    output logic                       o_mem_phase,
    output logic                       o_halted,
    output logic [NUM_BP-1:0]          o_bp_hit,
    output logic [31:0]                o_retired
);

    localparam logic [DIV_WIDTH-1:0] DIV_ONE = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [DIV_WIDTH-1:0] r_div_cnt;
    logic                 w_tick;

    run_state_t           r_state;
    logic [1:0]           r_mode_prev;
    logic                 r_cpu_ce;
    logic                 r_mem_phase;
    logic                 r_halted;
    logic                 r_step_pending;
    logic [CNT_WIDTH-1:0] r_remaining;
    logic [NUM_BP-1:0]    r_bp_hit;
    logic [31:0]          r_retired;

    logic                 w_step_pulse;
    logic                 w_mode_chg;
    logic [NUM_BP-1:0]    w_bp_match;
    logic                 w_bp_any;

    core_run_ctrl_step_sync u_step_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_step  (i_step),
        .o_pulse (w_step_pulse)
    );

    // >= rather than == so shrinking div_sel below the count ticks at once instead of wrapping.
    assign w_tick = (r_div_cnt >= i_div_sel);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_ONE;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_BP; g++) begin : g_bp
            assign w_bp_match[g] = i_bp_en[g] && (i_pc == i_bp_addr[g*PC_WIDTH +: PC_WIDTH]);
        end
    endgenerate

    assign w_bp_any   = |w_bp_match;
    assign w_mode_chg = (i_mode != r_mode_prev);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_HALT;
            r_mode_prev    <= MODE_HALT;
            r_cpu_ce       <= 1'b0;
            r_halted       <= 1'b1;
            r_step_pending <= 1'b0;
            r_remaining    <= '0;
            r_bp_hit       <= '0;
        end else begin
            r_mode_prev <= i_mode;
            r_cpu_ce    <= 1'b0;
            if (w_mode_chg) begin
                r_state        <= mode_state(i_mode);
                r_halted       <= (mode_state(i_mode) == ST_HALT);
                r_step_pending <= 1'b0;
                r_remaining    <= '0;
                r_bp_hit       <= '0;
            end else if (i_start && (i_mode == MODE_RUN_N)) begin
                r_step_pending <= 1'b0;
                r_remaining    <= i_run_count;
                if (i_run_count != '0) begin
                    r_state  <= ST_RUN_N;
                    r_halted <= 1'b0;
                end else begin
                    r_state  <= ST_HALT;
                    r_halted <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (w_tick) begin
                            if (w_bp_any) begin
                                r_state        <= ST_BREAK;
                                r_halted       <= 1'b1;
                                r_bp_hit       <= r_bp_hit | w_bp_match;
                                r_step_pending <= 1'b0;
                            end else begin
                                r_cpu_ce <= 1'b1;
                            end
                        end
                    end
                    ST_RUN_N: begin
                        if (w_tick && (r_remaining != '0)) begin
                            if (w_bp_any) begin
                                r_state        <= ST_BREAK;
                                r_halted       <= 1'b1;
                                r_bp_hit       <= r_bp_hit | w_bp_match;
                                r_step_pending <= 1'b0;
                            end else begin
                                r_cpu_ce    <= 1'b1;
                                r_remaining <= r_remaining - CNT_ONE;
                                if (r_remaining == CNT_ONE) begin
                                    r_state  <= ST_HALT;
                                    r_halted <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_STEP: begin
                        if (w_tick && r_step_pending) begin
                            r_cpu_ce       <= 1'b1;
                            r_step_pending <= 1'b0;
                        end else if (w_step_pulse) begin
                            r_step_pending <= 1'b1;
                        end
                    end
                    ST_BREAK: begin
                        // The step-out ce ignores the comparators, so the CPU can leave the breakpoint PC.
                        if (w_tick && r_step_pending) begin
                            r_cpu_ce       <= 1'b1;
                            r_step_pending <= 1'b0;
                            if (i_mode == MODE_RUN_N) begin
                                r_remaining <= r_remaining - CNT_ONE;
                                if (r_remaining == CNT_ONE) begin
                                    r_state  <= ST_HALT;
                                    r_halted <= 1'b1;
                                end else begin
                                    r_state  <= ST_RUN_N;
                                    r_halted <= 1'b0;
                                end
                            end else begin
                                r_state  <= ST_RUN;
                                r_halted <= 1'b0;
                            end
                        end else if (w_step_pulse) begin
                            r_step_pending <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem_phase <= 1'b0;
            r_retired   <= '0;
        end else begin
            r_mem_phase <= r_cpu_ce;
            if (r_cpu_ce && !i_stall) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign o_cpu_ce    = r_cpu_ce;
    assign o_mem_phase = r_mem_phase;
    assign o_halted    = r_halted;
    assign o_bp_hit    = r_bp_hit;
    assign o_retired   = r_retired;

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb/tb_core_run_ctrl.sv - scoreboard bench for core_run_ctrl
module tb_core_run_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   mode = 2'b00;
    logic [3:0]   div_sel = 4'd0;
    logic         step = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  run_count = 16'd0;
    logic [63:0]  pc;
    logic [127:0] bp_addr = '0;
    logic [1:0]   bp_en = 2'b00;
    logic         stall = 1'b0;
    logic         cpu_ce;
    logic         mem_phase;
    logic         halted;
    logic [1:0]   bp_hit;
    logic [31:0]  retired;

    always #5 clk = ~clk;

    core_run_ctrl #(
        .DIV_WIDTH (4),
        .PC_WIDTH  (64),
        .NUM_BP    (2),
        .CNT_WIDTH (16)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mode      (mode),
        .i_div_sel   (div_sel),
        .i_step      (step),
        .i_start     (start),
        .i_run_count (run_count),
        .i_pc        (pc),
        .i_bp_addr   (bp_addr),
        .i_bp_en     (bp_en),
        .i_stall     (stall),
        .o_cpu_ce    (cpu_ce),
        .o_mem_phase (mem_phase),
        .o_halted    (halted),
        .o_bp_hit    (bp_hit),
        .o_retired   (retired)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input logic [63:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check(e.tag, obs, e.val);
        end
    endtask

    // CPU model: pc advances by 4 on every observed cpu_ce.
    int          cyc = 0;
    int          ce_cnt = 0;
    int          mp_bad = 0;
    logic        prev_ce = 1'b0;
    int          ce_times[$];
    logic [63:0] pc_base = 64'h0;
    int          ce_mark = 0;

    assign pc = pc_base + 64'(4 * (ce_cnt - ce_mark));

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            prev_ce <= 1'b0;
        end else begin
            if (mem_phase !== prev_ce) mp_bad <= mp_bad + 1;
            prev_ce <= cpu_ce;
            if (cpu_ce) begin
                ce_cnt <= ce_cnt + 1;
                ce_times.push_back(cyc);
            end
        end
    end

    task automatic wait_ce(input int budget, output int t);
        int seen;
        seen = 0;
        t = 0;
        for (int i = 0; i < budget && seen == 0; i++) begin
            @(negedge clk);
            if (cpu_ce) begin
                seen = 1;
                t = cyc;
            end
        end
        if (seen == 0) check("ce_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int i0;
        int t0;
        int t1;
        int t2;
        logic [31:0] r0;

        repeat (3) @(negedge clk);
        check("rst_cpu_ce", {63'd0, cpu_ce}, 64'd0);
        check("rst_mem_phase", {63'd0, mem_phase}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd1);
        check("rst_bp_hit", {62'd0, bp_hit}, 64'd0);
        check("rst_retired", {32'd0, retired}, 64'd0);
        rst = 1'b0;

        // RUN, tick every 4 clocks
        div_sel = 4'd3;
        mode = 2'b01;
        repeat (3) @(negedge clk);
        c0 = ce_cnt;
        r0 = retired;
        i0 = ce_times.size();
        expect_val("run_ce_count", 64'd10);
        expect_val("run_retired", 64'd10);
        repeat (40) @(negedge clk);
        sb_check(64'(ce_cnt - c0));
        sb_check({32'd0, retired - r0});
        for (int k = i0 + 1; k < ce_times.size(); k++) begin
            expect_val("run_gap", 64'd4);
            sb_check(64'(ce_times[k] - ce_times[k-1]));
        end

        // stall only masks the retired count
        wait_ce(20, t0);
        @(negedge clk);
        expect_val("mem_phase_after_ce", 64'd1);
        sb_check({63'd0, mem_phase});
        r0 = retired;
        expect_val("stall_retired", 64'd5);
        for (int i = 0; i < 8; i++) begin
            wait_ce(20, t0);
            stall = (i < 3);
            @(negedge clk);
            stall = 1'b0;
        end
        sb_check({32'd0, retired - r0});

        // shrinking div_sel below the running count
        div_sel = 4'd7;
        wait_ce(20, t0);
        repeat (5) @(negedge clk);
        div_sel = 4'd1;
        expect_val("div_shrink_gap", 64'd6);
        expect_val("div_new_gap", 64'd2);
        wait_ce(20, t1);
        wait_ce(20, t2);
        sb_check(64'(t1 - t0));
        sb_check(64'(t2 - t1));

        // STEP: three presses
        mode = 2'b10;
        repeat (3) @(negedge clk);
        c0 = ce_cnt;
        expect_val("step_three", 64'd3);
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            repeat (6) @(negedge clk);
            step = 1'b0;
            repeat (6) @(negedge clk);
        end
        sb_check(64'(ce_cnt - c0));

        // second press while pending is dropped
        div_sel = 4'd15;
        mode = 2'b01;
        wait_ce(40, t0);
        @(negedge clk);
        mode = 2'b10;
        repeat (2) @(negedge clk);
        c0 = ce_cnt;
        step = 1'b1;
        repeat (2) @(negedge clk);
        step = 1'b0;
        repeat (2) @(negedge clk);
        step = 1'b1;
        repeat (2) @(negedge clk);
        step = 1'b0;
        expect_val("step_drop", 64'd1);
        repeat (20) @(negedge clk);
        sb_check(64'(ce_cnt - c0));

        // async reset in the middle of a press
        div_sel = 4'd1;
        step = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        expect_val("rst_async_halted", 64'd1);
        expect_val("rst_async_ce", 64'd0);
        sb_check({63'd0, halted});
        sb_check({63'd0, cpu_ce});
        step = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        c0 = ce_cnt;
        expect_val("rst_press_ce", 64'd0);
        expect_val("rst_retired_clear", 64'd0);
        repeat (20) @(negedge clk);
        sb_check(64'(ce_cnt - c0));
        sb_check({32'd0, retired});

        // RUN_N with budget 5, then budget 0
        mode = 2'b11;
        repeat (3) @(negedge clk);
        expect_val("runn_idle_halted", 64'd1);
        sb_check({63'd0, halted});
        c0 = ce_cnt;
        run_count = 16'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expect_val("runn_running", 64'd0);
        sb_check({63'd0, halted});
        expect_val("runn_ce5", 64'd5);
        expect_val("runn_done_halted", 64'd1);
        repeat (30) @(negedge clk);
        sb_check(64'(ce_cnt - c0));
        sb_check({63'd0, halted});
        c0 = ce_cnt;
        run_count = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expect_val("runn0_ce", 64'd0);
        expect_val("runn0_halted", 64'd1);
        repeat (10) @(negedge clk);
        sb_check(64'(ce_cnt - c0));
        sb_check({63'd0, halted});

        // breakpoint in RUN; entry 1 matches earlier but is disabled
        mode = 2'b00;
        bp_addr = {64'h0000_0000_8000_0008, 64'h0000_0000_8000_0010};
        bp_en = 2'b01;
        @(negedge clk);
        pc_base = 64'h0000_0000_8000_0000;
        ce_mark = ce_cnt;
        @(negedge clk);
        c0 = ce_cnt;
        mode = 2'b01;
        expect_val("bp_ce_before", 64'd4);
        expect_val("bp_hit", 64'd1);
        expect_val("bp_halted", 64'd1);
        repeat (20) @(negedge clk);
        sb_check(64'(ce_cnt - c0));
        sb_check({62'd0, bp_hit});
        sb_check({63'd0, halted});

        // step out of BREAK, then RUN resumes
        c0 = ce_cnt;
        step = 1'b1;
        wait_ce(20, t0);
        step = 1'b0;
        expect_val("bp_step_resume", 64'd0);
        expect_val("bp_hit_sticky", 64'd1);
        expect_val("bp_run_again", 64'd1);
        sb_check({63'd0, halted});
        sb_check({62'd0, bp_hit});
        repeat (10) @(negedge clk);
        sb_check({63'd0, (ce_cnt - c0) >= 3});

        // mode change to HALT on the same tick as a breakpoint match
        bp_en = 2'b00;
        div_sel = 4'd3;
        wait_ce(20, t0);
        wait_ce(20, t0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        pc_base = 64'h0000_0000_8000_0010;
        ce_mark = ce_cnt;
        c0 = ce_cnt;
        bp_en = 2'b01;
        mode = 2'b00;
        expect_val("modechg_ce", 64'd0);
        expect_val("modechg_bp_hit", 64'd0);
        expect_val("modechg_halted", 64'd1);
        repeat (10) @(negedge clk);
        sb_check(64'(ce_cnt - c0));
        sb_check({62'd0, bp_hit});
        sb_check({63'd0, halted});

        check("mem_phase_align", 64'(mp_bad), 64'd0);
        check("sb_leftover", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
